// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: opcodes, the scoreboard entry
// layout and small helpers used by the decode and stall logic.
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam int LINK_REG = 31;

  // Entry fields are sized for a 32-entry register file and latencies up to 15.
  localparam int REG_W = 5;
  localparam int RDY_W = 4;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic [RDY_W-1:0] rdy;
  } sb_entry_t;

  function automatic logic [RDY_W-1:0] rdyDec(input logic [RDY_W-1:0] r);
    return (r == '0) ? r : r - RDY_W'(1);
  endfunction

endpackage

// File: rtl/hazard_op_decode.sv
// Combinational opcode classifier: which sources are read, which register is
// written, whether the producer is a load, and how much slack the consumer has.
module hazard_op_decode
  import hazard_pkg::*;
#(
  parameter int RW           = 5,
  parameter bit BRANCH_IN_ID = 1'b1
) (
  input  logic [5:0]    opcode,
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  input  logic [RW-1:0] rd,
  output logic          readsRs,
  output logic          readsRt,
  output logic [RW-1:0] dest,
  output logic          isLoad,
  output logic          slack
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    readsRs = 1'b0;
    readsRt = 1'b0;
    dest    = '0;
    isLoad  = 1'b0;
    slack   = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        readsRs = 1'b1;
        readsRt = 1'b1;
        dest    = rd;
      end
      OP_LW: begin
        readsRs = 1'b1;
        dest    = rt;
        isLoad  = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: begin
        readsRs = 1'b1;
        dest    = rt;
      end
      OP_LUI: dest = rt;
      OP_SW: begin
        readsRs = 1'b1;
        readsRt = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        readsRs = 1'b1;
        readsRt = 1'b1;
        slack   = BRANCH_IN_ID ? 1'b0 : 1'b1;
      end
      OP_JAL: dest = RW'(LINK_REG);
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard_stall.sv
// Scoreboard-based interlock: tracks in-flight register writes past ID and
// stalls the ID instruction until every source it needs can be forwarded.
module hazard_scoreboard_stall
  import hazard_pkg::*;
#(
  parameter int RW           = 5,
  parameter int DEPTH        = 3,
  parameter int ALU_LAT      = 1,
  parameter int LOAD_LAT     = 2,
  parameter bit BRANCH_IN_ID = 1'b1,
  parameter int CNT_W        = 16,
  parameter int MAX_STALL    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic [RW-1:0]    id_rd,
  input  logic             flush,
  input  logic             pipe_hold,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count,
  output logic             stall_timeout,
  output logic             sb_busy
);

  localparam int CONS_W = $clog2(MAX_STALL + 1);

  sb_entry_t         sb [DEPTH];
  sb_entry_t         newEntry;
  logic [CONS_W-1:0] consec;
  logic              readsRs, readsRt, isLoad, slack;
  logic [RW-1:0]     dest;
  logic              hazRs, hazRt;
  logic [RDY_W-1:0]  slackExt;

  hazard_op_decode #(
    .RW           (RW),
    .BRANCH_IN_ID (BRANCH_IN_ID)
  ) u_decode (
    .opcode  (id_opcode),
    .rs      (id_rs),
    .rt      (id_rt),
    .rd      (id_rd),
    .readsRs (readsRs),
    .readsRt (readsRt),
    .dest    (dest),
    .isLoad  (isLoad),
    .slack   (slack)
  );

  always_comb begin
    slackExt = RDY_W'(slack);
    hazRs    = 1'b0;
    hazRt    = 1'b0;
    // Walk oldest to youngest so the youngest matching producer decides.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (sb[i].valid && sb[i].dest == id_rs) hazRs = (sb[i].rdy > slackExt);
      if (sb[i].valid && sb[i].dest == id_rt) hazRt = (sb[i].rdy > slackExt);
    end
    hazRs = hazRs && readsRs && (id_rs != '0);
    hazRt = hazRt && readsRt && (id_rt != '0);
  end

  assign stall = id_valid & ~flush & ~reset & (hazRs | hazRt);

  always_comb begin
    sb_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) sb_busy = sb_busy | sb[i].valid;
  end

  always_comb begin
    newEntry = '0;
    if (id_valid && !flush && !stall && dest != '0) begin
      newEntry = '{valid: 1'b1, dest: dest,
                   rdy: isLoad ? RDY_W'(LOAD_LAT) : RDY_W'(ALU_LAT)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the scoreboard is plain flops, so clearing every entry on reset is intended.
      for (int i = 0; i < DEPTH; i++) sb[i] <= '0;
      stall_count   <= '0;
      stall_timeout <= 1'b0;
      consec        <= '0;
    end else if (!pipe_hold) begin
      // NOTE: non-blocking updates make every entry shift from its pre-edge neighbour.
      sb[0] <= newEntry;
      for (int i = 1; i < DEPTH; i++) begin
        sb[i] <= '{valid: sb[i-1].valid, dest: sb[i-1].dest, rdy: rdyDec(sb[i-1].rdy)};
      end
      if (stall) begin
        if (stall_count != '1) stall_count <= stall_count + CNT_W'(1);
        if (consec >= CONS_W'(MAX_STALL)) stall_timeout <= 1'b1;
        else                              consec <= consec + CONS_W'(1);
      end else begin
        consec <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_stall.sv
// Drives three differently parameterised scoreboards with shared stimulus and
// checks each against an age-based model of in-flight writes.
module tb_hazard_scoreboard_stall;
  import hazard_pkg::*;

  localparam int NCFG = 3;
  localparam int LLAT [NCFG] = '{2, 3, 9};
  localparam int DEP  [NCFG] = '{3, 4, 10};
  localparam int MAXST   = 8;
  localparam int CNT_MAX = 65535;

  logic       clk, reset, idValid, flush, pipeHold;
  logic [5:0] idOpcode;
  logic [4:0] idRs, idRt, idRd;
  logic       stall0, stall1, stall2, busy0, busy1, busy2, tout0, tout1, tout2;
  logic [15:0] cnt0, cnt1, cnt2;

  hazard_scoreboard_stall dut0 (
    .clk(clk), .reset(reset), .id_valid(idValid), .id_opcode(idOpcode),
    .id_rs(idRs), .id_rt(idRt), .id_rd(idRd), .flush(flush), .pipe_hold(pipeHold),
    .stall(stall0), .stall_count(cnt0), .stall_timeout(tout0), .sb_busy(busy0));

  hazard_scoreboard_stall #(.DEPTH(4), .LOAD_LAT(3)) dut1 (
    .clk(clk), .reset(reset), .id_valid(idValid), .id_opcode(idOpcode),
    .id_rs(idRs), .id_rt(idRt), .id_rd(idRd), .flush(flush), .pipe_hold(pipeHold),
    .stall(stall1), .stall_count(cnt1), .stall_timeout(tout1), .sb_busy(busy1));

  hazard_scoreboard_stall #(.DEPTH(10), .LOAD_LAT(9)) dut2 (
    .clk(clk), .reset(reset), .id_valid(idValid), .id_opcode(idOpcode),
    .id_rs(idRs), .id_rt(idRt), .id_rd(idRd), .flush(flush), .pipe_hold(pipeHold),
    .stall(stall2), .stall_count(cnt2), .stall_timeout(tout2), .sb_busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCFG-1:0]       stall;
    logic [NCFG-1:0]       busy;
    logic [NCFG-1:0]       tout;
    logic [NCFG-1:0][15:0] cnt;
  } exp_t;

  typedef struct {
    int cfg;
    int dest;
    int lat;
    int birth;
  } fly_t;

  exp_t expQ[$];
  fly_t fly[$];
  int   tick;
  int   mCount [NCFG];
  int   mConsec[NCFG];
  bit   mTout  [NCFG];
  int   tests = 0;
  int   fails = 0;
  logic [5:0] ops [14] = '{6'd0, 6'd35, 6'd8, 6'd9, 6'd10, 6'd12, 6'd13,
                           6'd15, 6'd43, 6'd4, 6'd5, 6'd3, 6'd2, 6'd63};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference decode written straight from the instruction table.
  function automatic void decodeRef(input logic [5:0] op, input int rs, input int rt, input int rd,
                                    output bit rRs, output bit rRt, output int dst,
                                    output bit ld, output int slk);
    rRs = 0; rRt = 0; dst = 0; ld = 0; slk = 1;
    case (int'(op))
      0:              begin rRs = 1; rRt = 1; dst = rd; end
      35:             begin rRs = 1; dst = rt; ld = 1; end
      8, 9, 10, 12, 13: begin rRs = 1; dst = rt; end
      15:             dst = rt;
      43:             begin rRs = 1; rRt = 1; end
      4, 5:           begin rRs = 1; rRt = 1; slk = 0; end
      3:              dst = 31;
      default: ;
    endcase
  endfunction

  // A write issued at tick b has age tick-b; it is tracked while age < DEPTH
  // and still needs max(lat-age,0) cycles before it can be forwarded.
  function automatic bit modelHaz(input int c, input int s, input bit reads, input int slk);
    int best = -1;
    int rem  = 0;
    if (!reads || s == 0) return 0;
    foreach (fly[k]) begin
      if (fly[k].cfg == c && tick - fly[k].birth < DEP[c] && fly[k].dest == s &&
          fly[k].birth > best) begin
        best = fly[k].birth;
        rem  = fly[k].lat - (tick - fly[k].birth);
      end
    end
    return (best >= 0) && (rem > slk);
  endfunction

  function automatic bit modelBusy(input int c);
    foreach (fly[k]) if (fly[k].cfg == c && tick - fly[k].birth < DEP[c]) return 1;
    return 0;
  endfunction

  task automatic step(input bit v, input logic [5:0] op, input int rs, input int rt, input int rd,
                      input bit fl, input bit hold, input bit rst, output logic [NCFG-1:0] st);
    bit rRs, rRt, ld;
    int dst, slk;
    exp_t e;
    @(negedge clk);
    idValid = v; idOpcode = op; idRs = 5'(rs); idRt = 5'(rt); idRd = 5'(rd);
    flush = fl; pipeHold = hold; reset = rst;
    if (rst) begin
      fly.delete();
      for (int c = 0; c < NCFG; c++) begin mCount[c] = 0; mConsec[c] = 0; mTout[c] = 0; end
    end
    decodeRef(op, rs, rt, rd, rRs, rRt, dst, ld, slk);
    e = '0;
    for (int c = 0; c < NCFG; c++) begin
      st[c] = v && !fl && !rst && (modelHaz(c, rs, rRs, slk) || modelHaz(c, rt, rRt, slk));
      e.stall[c] = st[c];
      e.busy[c]  = modelBusy(c);
      e.tout[c]  = mTout[c];
      e.cnt[c]   = 16'(mCount[c]);
    end
    expQ.push_back(e);
    @(posedge clk);
    if (!rst && !hold) begin
      for (int c = 0; c < NCFG; c++) begin
        if (st[c]) begin
          if (mCount[c] < CNT_MAX) mCount[c]++;
          mConsec[c]++;
          if (mConsec[c] > MAXST) mTout[c] = 1;
        end else begin
          mConsec[c] = 0;
        end
      end
      tick++;
      if (v && !fl && dst != 0)
        for (int c = 0; c < NCFG; c++)
          if (!st[c]) fly.push_back('{c, dst, ld ? LLAT[c] : 1, tick});
      for (int k = fly.size() - 1; k >= 0; k--)
        if (tick - fly[k].birth >= 16) fly.delete(k);
    end
  endtask

  // Hold the instruction in ID while the chosen configuration stalls it.
  task automatic issue(input int cfg, input logic [5:0] op, input int rs, input int rt, input int rd);
    logic [NCFG-1:0] st;
    int n = 0;
    do begin
      step(1, op, rs, rt, rd, 0, 0, 0, st);
      n++;
    end while (st[cfg] && n < 40);
    if (st[cfg]) begin
      tests++; fails++;
      $display("FAIL issue_bound: stall still %0d after %0d cycles, want 0", st[cfg], n);
    end
  endtask

  task automatic idle(input int n);
    logic [NCFG-1:0] st;
    repeat (n) step(0, OP_J, 0, 0, 0, 0, 0, 0, st);
  endtask

  task automatic doReset();
    logic [NCFG-1:0] st;
    repeat (2) step(0, OP_J, 0, 0, 0, 0, 0, 1, st);
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    logic [NCFG-1:0] gs, gb, gt;
    logic [NCFG-1:0][15:0] gc;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        e  = expQ.pop_front();
        gs = {stall2, stall1, stall0};
        gb = {busy2, busy1, busy0};
        gt = {tout2, tout1, tout0};
        gc = {cnt2, cnt1, cnt0};
        for (int c = 0; c < NCFG; c++) begin
          check($sformatf("stall_cfg%0d", c),   32'(gs[c]), 32'(e.stall[c]));
          check($sformatf("sb_busy_cfg%0d", c), 32'(gb[c]), 32'(e.busy[c]));
          check($sformatf("timeout_cfg%0d", c), 32'(gt[c]), 32'(e.tout[c]));
          check($sformatf("count_cfg%0d", c),   32'(gc[c]), 32'(e.cnt[c]));
        end
      end
    end
  end

  initial begin
    logic [NCFG-1:0] st;
    int w;
    reset = 1; idValid = 0; idOpcode = OP_J; idRs = 0; idRt = 0; idRd = 0;
    flush = 0; pipeHold = 0; tick = 0;
    doReset();

    // lw $8 then beq $8,$9: two stall cycles with default latencies.
    issue(0, OP_LW, 1, 8, 0);
    issue(0, OP_BEQ, 8, 9, 0);
    idle(12);
    #3;
    check("lw_beq_count_default", 32'(cnt0), 32'd2);
    check("lw_beq_count_lat3", 32'(cnt1), 32'd3);

    // R-type producer before a branch, directly and with a gap.
    issue(0, OP_RTYPE, 1, 2, 3);
    issue(0, OP_BEQ, 3, 0, 0);
    idle(12);
    issue(0, OP_RTYPE, 1, 2, 3);
    issue(0, OP_ADDI, 1, 10, 0);
    issue(0, OP_BEQ, 3, 0, 0);
    idle(12);

    // Load-use into ALU consumer, then ALU-to-ALU.
    issue(0, OP_LW, 1, 5, 0);
    issue(0, OP_RTYPE, 5, 7, 6);
    idle(12);
    issue(0, OP_ADDI, 1, 5, 0);
    issue(0, OP_RTYPE, 5, 7, 6);
    idle(12);

    // Youngest producer decides.
    issue(1, OP_LW, 1, 4, 0);
    issue(1, OP_ADDI, 1, 4, 0);
    issue(1, OP_RTYPE, 4, 7, 6);
    idle(12);

    // Flushed consumer neither stalls nor writes; $0 never creates a hazard.
    issue(0, OP_LW, 1, 8, 0);
    step(1, OP_RTYPE, 8, 7, 6, 1, 0, 0, st);
    issue(0, OP_RTYPE, 6, 7, 11);
    idle(12);
    issue(0, OP_ADDI, 1, 0, 0);
    issue(0, OP_RTYPE, 0, 0, 12);
    issue(0, OP_LW, 1, 0, 0);
    issue(0, OP_BEQ, 0, 0, 0);
    idle(12);

    // Pipeline hold freezes the scoreboard mid-hazard.
    doReset();
    issue(0, OP_LW, 1, 8, 0);
    step(1, OP_BEQ, 8, 9, 0, 0, 0, 0, st);
    repeat (5) step(1, OP_BEQ, 8, 9, 0, 0, 1, 0, st);
    issue(0, OP_BEQ, 8, 9, 0);
    idle(12);
    #3;
    check("hold_count_default", 32'(cnt0), 32'd2);

    // Watchdog on the long-latency configuration: 8 stalls pass, 9 trip it.
    doReset();
    issue(2, OP_LW, 1, 8, 0);
    issue(2, OP_RTYPE, 8, 7, 6);
    idle(12);
    #3;
    check("eight_stalls_no_timeout", 32'(tout2), 32'd0);
    check("eight_stalls_count", 32'(cnt2), 32'd8);
    issue(2, OP_LW, 1, 8, 0);
    issue(2, OP_BEQ, 8, 9, 0);
    idle(8);
    #3;
    check("nine_stalls_timeout", 32'(tout2), 32'd1);
    idle(5);
    #3;
    check("timeout_sticky", 32'(tout2), 32'd1);
    doReset();
    #3;
    check("timeout_cleared_by_reset", 32'(tout2), 32'd0);

    // Reset asserted while a load hazard is stalling ID.
    step(0, OP_J, 0, 0, 0, 0, 0, 0, st);
    issue(0, OP_LW, 1, 8, 0);
    step(1, OP_BEQ, 8, 9, 0, 0, 0, 1, st);
    #3;
    check("reset_mid_hazard_stall", 32'(stall0), 32'd0);
    check("reset_mid_hazard_busy", 32'(busy0), 32'd0);
    doReset();

    // Random traffic over a small register window to provoke hazards.
    repeat (2500) begin
      step(($urandom % 8) != 0, ops[$urandom_range(0, 13)],
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           ($urandom % 10) == 0, ($urandom % 10) == 0, ($urandom % 150) == 0, st);
    end
    idle(2);

    w = 0;
    while (expQ.size() > 0 && w < 5) begin
      @(negedge clk);
      #3;
      w++;
    end
    if (expQ.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expectations left, want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_stall.md
Name: hazard_scoreboard_stall

Overview:
- Parametrised successor to the fixed lw/R-type-before-beq stall logic.
- Tracks every in-flight register write in a shift-register scoreboard covering the stages after ID.
- Compares the ID-stage instruction's source registers against that scoreboard, using per-producer latency and per-consumer need point (branch resolved in ID, or ALU in EX).
- Drives the pipeline stall, keeps a stall-cycle performance counter, and raises a sticky watchdog on runaway stalls.

Parameters:
- RW, 5: register-index width.
- DEPTH, 3: scoreboard entries (EX, MEM, WB). Must satisfy DEPTH > LOAD_LAT.
- ALU_LAT, 1: cycles after entering EX before an ALU result can be forwarded to ID.
- LOAD_LAT, 2: same measure for a load result.
- BRANCH_IN_ID, 1: 1 means beq/bne need operands in ID (slack 0); 0 means slack 1.
- CNT_W, 16: width of the stall performance counter.
- MAX_STALL, 8: consecutive stall cycles allowed before timeout.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  6  ID opcode
- id_rs  in  RW  ID rs field
- id_rt  in  RW  ID rt field
- id_rd  in  RW  ID rd field
- flush  in  1  ID instruction is squashed this cycle
- pipe_hold  in  1  whole pipeline frozen (memory wait)
- stall  out  1  hold PC and IF/ID, inject a bubble into ID/EX
- stall_count  out  CNT_W  total stall cycles, saturating
- stall_timeout  out  1  sticky watchdog flag
- sb_busy  out  1  some scoreboard entry is valid

Behaviour:
- Scoreboard entry i (0 = EX) holds valid, dest[RW-1:0] and rdy[$clog2(LOAD_LAT+1)-1:0].
- Reset (asynchronous): all entries invalid, stall_count=0, stall_timeout=0, consecutive-stall counter=0. stall=0 while reset is asserted.
- Decode (combinational):
  - R-type (0): writes rd, reads rs and rt.
  - lw (35): writes rt, reads rs.
  - addi/addiu/slti/andi/ori (8/9/10/12/13): write rt, read rs.
  - lui (15): writes rt, reads nothing.
  - sw (43): reads rs and rt.
  - beq/bne (4/5): read rs and rt.
  - jal (3): writes 31.
  - j (2) and unknown opcodes: no reads, no writes.
  - A destination of 0 means no write.
- Producer latency: lw gets LOAD_LAT; every other writer gets ALU_LAT.
- Consumer slack: beq/bne get (BRANCH_IN_ID ? 0 : 1); every other reader gets 1.
- Stall rule:
  - For each read source s != 0, find the youngest valid entry (lowest index) with dest==s.
  - hazard(s) = that entry exists and its rdy > slack.
  - stall = id_valid & ~flush & ~reset & (hazard(rs) | hazard(rt)). It is combinational, with no added latency.
  - Older matches are ignored whenever a younger match exists.
- Each clock edge with pipe_hold=0:
  - Entries shift i -> i+1; entry DEPTH-1 is discarded.
  - Shifted rdy decrements, saturating at 0.
  - Entry 0 loads {1, dest, latency} when id_valid & ~flush & ~stall & (the instruction writes). Otherwise entry 0 is loaded invalid (bubble).
- pipe_hold=1: scoreboard, rdy values and the consecutive-stall counter are all frozen. stall is still evaluated, and stall_count does not advance.
- Counters, on each edge with pipe_hold=0:
  - stall=1: stall_count increments, saturating at all-ones; the consecutive counter increments.
  - stall=0: the consecutive counter clears.
  - When the consecutive counter would exceed MAX_STALL, stall_timeout is set. It stays set until reset.
- Simultaneous flush and hazard: flush wins. stall=0 and a bubble is inserted.
- Mid-operation reset: in-flight entries are lost; there is no partial state.
- sb_busy = OR of all entry valid bits.
- Default parameters reproduce the legacy cases:
  - lw in MEM followed by beq: stall.
  - R-type in EX followed by beq: stall.
  - R-type in MEM followed by beq: no stall.
  - New behaviour: load-use into an ALU consumer stalls one cycle.

Decomposition:
- Package hazard_pkg holds:
  - opcode constants OP_RTYPE, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_J, OP_JAL;
  - the scoreboard entry struct sb_entry_t;
  - the link-register index constant.
- One combinational sub-module, hazard_op_decode: maps opcode and fields to {reads_rs, reads_rt, dest, is_load, slack}.

Test Plan:
- lw $8 issued, then beq $8,$9 in ID one cycle later -> stall=1 for 2 cycles, then 0; stall_count=2.
- add $3 in EX, beq $3,$0 in ID -> stall=1 for exactly 1 cycle. Same pair with one independent instruction between -> stall never asserts.
- lw $5, then immediately add $6,$5,$7 -> stall=1 for 1 cycle. addi $5 then add using $5 -> no stall.
- Older lw $4 followed by younger addi $4, then add reading $4 with LOAD_LAT=3 -> no stall (youngest match rule).
- Hazard present with flush=1 -> stall=0 and no entry inserted. Consumer of $0 after a write to $0 -> no stall.
- pipe_hold=1 for 5 cycles during a load hazard -> rdy frozen and stall_count unchanged. Forced 9 consecutive stalls with MAX_STALL=8 -> stall_timeout=1 until reset. Asynchronous reset mid-hazard -> stall=0 immediately and sb_busy=0.
